// File: rtl/captura_amostras_pkg.sv
// Shared definitions for the sample capture path: FSM encoding, default sizes
// and the trigger comparison used by the capture controller.
package captura_amostras_pkg;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 256;
    localparam int ADDR_W  = 8;
    localparam int DECIM_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // A zero level fires on any valid sample, since prev < 0 can never be true.
    function automatic logic trig_hit(input logic [DATA_W-1:0] prev,
                                      input logic [DATA_W-1:0] cur,
                                      input logic [DATA_W-1:0] level);
        return (level == '0) || ((prev < level) && (cur >= level));
    endfunction

endpackage

// File: rtl/ram_amostras_dp.sv
// Simple dual-port sample buffer: one write port, one registered read port,
// written so synthesis maps it onto block RAM.
module ram_amostras_dp #(
    parameter int P_WIDTH  = 64,
    parameter int P_DEPTH  = 256,
    parameter int P_ADDR_W = 8
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [P_ADDR_W-1:0] i_wr_addr,
    input  logic [P_WIDTH-1:0]  i_wr_data,
    input  logic                i_rd_en,
    input  logic [P_ADDR_W-1:0] i_rd_addr,
    output logic [P_WIDTH-1:0]  o_rd_data
);

    logic [P_WIDTH-1:0] r_mem [P_DEPTH];
    logic [P_WIDTH-1:0] r_rd_data;

    // NOTE: no reset on the array or its read register; a reset here would stop
    // block-RAM inference and the contents are don't-care after reset anyway.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/captura_amostras.sv
// Level-triggered capture of voltage/current sample pairs into an on-chip buffer,
// with optional decimation and random-address readback once capture is not running.
module captura_amostras
    import captura_amostras_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                abort,
    input  logic [DATA_W-1:0]   trig_level,
    input  logic [DECIM_W-1:0]  decim,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   tensao_in,
    input  logic [DATA_W-1:0]   corrente_in,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_tensao,
    output logic [DATA_W-1:0]   rd_corrente,
    output logic                rd_valid,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     wr_count
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [DECIM_W-1:0]   r_decim;
    logic [DECIM_W-1:0]   r_decim_cnt;
    logic [DATA_W-1:0]    r_prev_tensao;
    logic [ADDR_W:0]      r_wr_count;
    logic                 r_rd_valid;
    logic                 r_rd_loaded;

    logic                 w_arm_ok;
    logic                 w_trig;
    logic                 w_wr_en;
    logic                 w_cnt_step;
    logic                 w_last_wr;
    logic                 w_rd_ok;
    logic                 w_busy;
    logic                 w_done;
    logic [2*DATA_W-1:0]  w_rd_data;

    assign w_trig    = in_valid && trig_hit(r_prev_tensao, tensao_in, trig_level);
    assign w_last_wr = w_wr_en && (r_wr_count == LAST_IDX);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides everything, including a same-cycle arm.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: if (arm) w_next_state = ST_ARMED;
                ST_ARMED:         if (w_trig) w_next_state = w_last_wr ? ST_DONE : ST_CAPTURE;
                ST_CAPTURE:       if (w_last_wr) w_next_state = ST_DONE;
                default:          w_next_state = ST_IDLE;
            endcase
        end
    end

    // Output/strobe logic decoded from the current state.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_arm_ok   = 1'b0;
        w_wr_en    = 1'b0;
        w_cnt_step = 1'b0;
        w_rd_ok    = rd_en;
        unique case (r_state)
            ST_IDLE: begin
                w_arm_ok = arm && !abort;
            end
            ST_ARMED: begin
                w_busy     = 1'b1;
                w_wr_en    = w_trig && !abort;
                w_cnt_step = w_trig && !abort;
            end
            ST_CAPTURE: begin
                w_busy     = 1'b1;
                w_rd_ok    = 1'b0;
                w_wr_en    = in_valid && !abort && (r_decim_cnt == '0);
                w_cnt_step = in_valid && !abort;
            end
            ST_DONE: begin
                w_done   = 1'b1;
                w_arm_ok = arm && !abort;
            end
            default: ;
        endcase
    end

    // Capture datapath: decimation, trigger history and write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_decim       <= '0;
            r_decim_cnt   <= '0;
            r_prev_tensao <= '0;
            r_wr_count    <= '0;
        end else if (w_arm_ok) begin
            r_decim       <= decim;
            r_decim_cnt   <= '0;
            r_prev_tensao <= '0;
            r_wr_count    <= '0;
        end else begin
            if ((r_state == ST_ARMED) && in_valid && !abort) begin
                r_prev_tensao <= tensao_in;
            end
            if (w_wr_en) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
            // The trigger sample counts as phase 0 of the decimation cycle.
            if (w_cnt_step) begin
                r_decim_cnt <= (r_decim_cnt == r_decim) ? '0 : r_decim_cnt + 1'b1;
            end
        end
    end

    // Readback handshake; r_rd_loaded masks the unreset RAM output until a real read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_rd_loaded <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_loaded <= 1'b1;
            end
        end
    end

    ram_amostras_dp #(
        .P_WIDTH  (2*DATA_W),
        .P_DEPTH  (DEPTH),
        .P_ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_count[ADDR_W-1:0]),
        .i_wr_data ({tensao_in, corrente_in}),
        .i_rd_en   (w_rd_ok),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign rd_tensao   = r_rd_loaded ? w_rd_data[2*DATA_W-1:DATA_W] : '0;
    assign rd_corrente = r_rd_loaded ? w_rd_data[DATA_W-1:0]        : '0;
    assign rd_valid    = r_rd_valid;
    assign busy        = w_busy;
    assign done        = w_done;
    assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_captura_amostras.sv
// Directed bench for captura_amostras: trigger, decimation, abort, readback
// and reset scenarios with hand-computed expected values.
module tb_captura_amostras;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        abort;
    logic [31:0] trig_level;
    logic [7:0]  decim;
    logic        in_valid;
    logic [31:0] tensao_in;
    logic [31:0] corrente_in;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_tensao;
    logic [31:0] rd_corrente;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [8:0]  wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    captura_amostras dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .abort       (abort),
        .trig_level  (trig_level),
        .decim       (decim),
        .in_valid    (in_valid),
        .tensao_in   (tensao_in),
        .corrente_in (corrente_in),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_tensao   (rd_tensao),
        .rd_corrente (rd_corrente),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done),
        .wr_count    (wr_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] t, input logic [31:0] c);
        in_valid    = 1'b1;
        tensao_in   = t;
        corrente_in = c;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic do_arm(input logic [31:0] lvl, input logic [7:0] d);
        trig_level = lvl;
        decim      = d;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [7:0] a,
                           input logic [31:0] et, input logic [31:0] ec);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        check({tag, ".valid"}, rd_valid, 1);
        check({tag, ".tensao"}, rd_tensao, et);
        check({tag, ".corrente"}, rd_corrente, ec);
    endtask

    function automatic logic [31:0] cur3(input logic [31:0] v);
        return v * 3 + 1;
    endfunction

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_level = '0; decim = '0;
        in_valid = 1'b0; tensao_in = '0; corrente_in = '0; rd_en = 1'b0; rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.wr_count", wr_count, 0);
        check("rst.rd_valid", rd_valid, 0);
        check("rst.rd_tensao", rd_tensao, 0);

        // 1: ramp, level 100, no decimation
        do_arm(100, 0);
        check("t1.busy_armed", busy, 1);
        for (int v = 0; v < 100; v++) send(v, cur3(v));
        check("t1.no_trig_wr_count", wr_count, 0);
        for (int v = 100; v < 512; v++) send(v, cur3(v));
        check("t1.done", done, 1);
        check("t1.busy", busy, 0);
        check("t1.wr_count", wr_count, 256);
        do_read("t1.p0", 0, 100, cur3(100));
        do_read("t1.p255", 255, 355, cur3(355));
        rd_en = 1'b1; rd_addr = 8'd1; tick();
        check("t1.b2b1.valid", rd_valid, 1);
        check("t1.b2b1.tensao", rd_tensao, 101);
        rd_addr = 8'd2; tick();
        check("t1.b2b2.valid", rd_valid, 1);
        check("t1.b2b2.tensao", rd_tensao, 102);
        rd_en = 1'b0; tick();
        check("t1.rd_valid_drop", rd_valid, 0);

        // 2: same ramp, decimation by 4
        do_arm(100, 3);
        check("t2.wr_count_cleared", wr_count, 0);
        for (int v = 0; v < 1200; v++) send(v, cur3(v));
        check("t2.done", done, 1);
        check("t2.wr_count", wr_count, 256);
        do_read("t2.p10", 10, 140, cur3(140));
        do_read("t2.p1", 1, 104, cur3(104));
        do_read("t2.p255", 255, 1120, cur3(1120));

        // 3: signal never crosses the level
        do_arm(100, 0);
        for (int i = 0; i < 30; i++) send(50, 7);
        check("t3.busy", busy, 1);
        check("t3.wr_count", wr_count, 0);
        check("t3.done", done, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t3.abort_busy", busy, 0);
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        check("t3.arm_abort_busy", busy, 0);

        // 4: abort after 20 stored samples; arm while capturing is ignored
        do_arm(100, 0);
        for (int v = 90; v < 110; v++) send(v, cur3(v));
        arm = 1'b1; tick(); arm = 1'b0;
        check("t4.arm_ignored", wr_count, 10);
        for (int v = 110; v < 120; v++) send(v, cur3(v));
        abort = 1'b1; tick(); abort = 1'b0;
        check("t4.busy", busy, 0);
        check("t4.wr_count", wr_count, 20);
        do_read("t4.p19", 19, 119, cur3(119));
        do_arm(100, 0);
        check("t4.rearm_wr_count", wr_count, 0);

        // 5: readback refused during capture, then reset mid-capture
        for (int v = 95; v < 106; v++) send(v, cur3(v));
        rd_en = 1'b1; rd_addr = 8'd0; tick(); rd_en = 1'b0;
        check("t5.rd_in_capture_valid", rd_valid, 0);
        check("t5.rd_in_capture_hold", rd_tensao, 119);
        check("t5.wr_count", wr_count, 6);
        rst = 1'b1; in_valid = 1'b1; tensao_in = 200; tick(); in_valid = 1'b0; rst = 1'b0;
        check("t5.rst_busy", busy, 0);
        check("t5.rst_done", done, 0);
        check("t5.rst_wr_count", wr_count, 0);
        check("t5.rst_rd_valid", rd_valid, 0);
        check("t5.rst_rd_tensao", rd_tensao, 0);
        check("t5.rst_rd_corrente", rd_corrente, 0);

        // 6: gapped valid, level 0, decimation by 2
        do_arm(0, 1);
        tensao_in = 32'hFFFF_0000; tick();
        check("t6.no_trig_without_valid", wr_count, 0);
        for (int k = 0; k < 20; k++) begin
            send(1000 + 7 * k, (1000 + 7 * k) / 2);
            tensao_in = 32'hDEAD_BEEF; corrente_in = 32'h1234_5678;
            tick(); tick();
        end
        check("t6.wr_count", wr_count, 10);
        check("t6.busy", busy, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        do_read("t6.p0", 0, 1000, 500);
        do_read("t6.p3", 3, 1042, 521);
        do_read("t6.p9", 9, 1126, 563);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
